// File: rtl/deskew_rx_if.sv
// Bundles the per-lane inputs and aligned outputs of the deskew receiver.
// master drives the lanes (upstream AM lock stages), slave is deskew_rx.
interface deskew_rx_if #(
  parameter int BLOCK_W = 66,
  parameter int LANE_N  = 4
);
  logic [LANE_N-1:0]         lock_v_i;
  logic [LANE_N*LANE_N-1:0]  lane_i;
  logic [LANE_N-1:0]         valid_i;
  logic [LANE_N-1:0]         am_v_i;
  logic [LANE_N*BLOCK_W-1:0] block_i;
  logic                      valid_o;
  logic [LANE_N*BLOCK_W-1:0] block_o;
  logic                      deskew_v_o;
  logic                      err_o;

  modport master (
    output lock_v_i, lane_i, valid_i, am_v_i, block_i,
    input  valid_o, block_o, deskew_v_o, err_o
  );

  modport slave (
    input  lock_v_i, lane_i, valid_i, am_v_i, block_i,
    output valid_o, block_o, deskew_v_o, err_o
  );
endinterface

// File: rtl/deskew_rx.sv
// Multi-lane RX deskew: per-lane FIFOs buffer from each lane's alignment marker,
// then all lanes pop together with AMs stripped and blocks reordered to logical lanes.
module deskew_rx #(
  parameter int BLOCK_W  = 66,
  parameter int LANE_N   = 4,
  parameter int MAX_SKEW = 16
) (
  input logic       clk,
  input logic       reset,
  deskew_rx_if.slave rx
);

  localparam int AW = $clog2(MAX_SKEW);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    ALIGNED = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [LANE_N-1:0]               armed_q, armed_d;
  logic [LANE_N-1:0][LANE_N-1:0]   map_q, map_d;
  logic [LANE_N-1:0][PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [LANE_N-1:0][PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                            valid_q, valid_d;
  logic [LANE_N-1:0][BLOCK_W-1:0]  block_q, block_d;
  logic                            deskew_q, deskew_d;
  logic                            err_q, err_d;

  logic [BLOCK_W-1:0]              mem_q [LANE_N][MAX_SKEW];
  logic [LANE_N-1:0][BLOCK_W-1:0]  block_in;
  logic [LANE_N-1:0][BLOCK_W-1:0]  head;
  logic [LANE_N-1:0]               empty, full, wr_en;
  logic [LANE_N-1:0]               lane_seen;
  logic                            map_ok, lock_all, pop, overflow;

  assign block_in = rx.block_i;
  assign lock_all = &rx.lock_v_i;

  // A map is a permutation when every field is one-hot and together they cover all lanes.
  always_comb begin
    map_ok    = 1'b1;
    lane_seen = '0;
    for (int p = 0; p < LANE_N; p++) begin
      empty[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
      full[p]  = (wr_ptr_q[p][AW] != rd_ptr_q[p][AW]) &&
                 (wr_ptr_q[p][AW-1:0] == rd_ptr_q[p][AW-1:0]);
      head[p]  = mem_q[p][rd_ptr_q[p][AW-1:0]];
      if (!$onehot(rx.lane_i[p*LANE_N +: LANE_N])) map_ok = 1'b0;
      lane_seen = lane_seen | rx.lane_i[p*LANE_N +: LANE_N];
    end
    if (lane_seen != {LANE_N{1'b1}}) map_ok = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    map_d    = map_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = '0;
    pop      = 1'b0;
    overflow = 1'b0;
    valid_d  = 1'b0;
    block_d  = block_q;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (lock_all && map_ok) begin
          state_d = FILL;
          map_d   = rx.lane_i;
        end
      end
      FILL: begin
        for (int p = 0; p < LANE_N; p++) begin
          if (rx.valid_i[p] && rx.am_v_i[p]) begin
            armed_d[p] = 1'b1;
          end else if (rx.valid_i[p] && armed_q[p]) begin
            wr_en[p] = 1'b1;
            if (full[p]) overflow = 1'b1;
          end
        end
        if (&armed_q) state_d = ALIGNED;
      end
      ALIGNED: begin
        pop = &(~empty);
        for (int p = 0; p < LANE_N; p++) begin
          if (rx.valid_i[p] && !rx.am_v_i[p]) begin
            wr_en[p] = 1'b1;
            if (full[p] && !pop) overflow = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Lock loss wins over overflow: silent return to IDLE with no error pulse.
    if (state_q != IDLE) begin
      if (!lock_all) begin
        state_d = IDLE;
        wr_en   = '0;
        pop     = 1'b0;
      end else if (overflow) begin
        state_d = IDLE;
        err_d   = 1'b1;
        wr_en   = '0;
        pop     = 1'b0;
      end
    end

    for (int p = 0; p < LANE_N; p++) begin
      if (wr_en[p]) wr_ptr_d[p] = wr_ptr_q[p] + PW'(1);
      if (pop)      rd_ptr_d[p] = rd_ptr_q[p] + PW'(1);
    end

    if (state_d == IDLE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      armed_d  = '0;
    end

    // Physical lane p lands in logical slot k wherever its one-hot id has bit k set.
    if (pop) begin
      valid_d = 1'b1;
      for (int k = 0; k < LANE_N; k++) begin
        for (int p = 0; p < LANE_N; p++) begin
          if (map_q[p][k]) block_d[k] = head[p];
        end
      end
    end

    deskew_d = (state_d == ALIGNED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      armed_q  <= '0;
      map_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      block_q  <= '0;
      deskew_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      map_q    <= map_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      block_q  <= block_d;
      deskew_q <= deskew_d;
      err_q    <= err_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int p = 0; p < LANE_N; p++) begin
      if (wr_en[p]) mem_q[p][wr_ptr_q[p][AW-1:0]] <= block_in[p];
    end
  end

  assign rx.valid_o    = valid_q;
  assign rx.block_o    = block_q;
  assign rx.deskew_v_o = deskew_q;
  assign rx.err_o      = err_q;

endmodule

// File: tb/tb_deskew_rx.sv
// Randomized scoreboard bench for deskew_rx: a per-lane queue model predicts aligned
// words, and a negedge monitor compares every valid_o against the predicted stream.
module tb_deskew_rx;

  localparam int BLOCK_W  = 66;
  localparam int LANE_N   = 4;
  localparam int MAX_SKEW = 16;
  localparam int W        = LANE_N * BLOCK_W;

  typedef logic [BLOCK_W-1:0] blk_t;
  typedef logic [W-1:0]       word_t;
  typedef logic [LANE_N*LANE_N-1:0] map_t;

  logic clk = 1'b0;
  logic reset;

  deskew_rx_if #(.BLOCK_W(BLOCK_W), .LANE_N(LANE_N)) rx ();

  deskew_rx #(.BLOCK_W(BLOCK_W), .LANE_N(LANE_N), .MAX_SKEW(MAX_SKEW)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    err_seen = 0;
  int    cyc = 0;
  int    first_valid_cyc = -1;
  int    first_data_cyc = -1;
  bit    err_allowed = 1'b0;
  int    offs [LANE_N];
  int    logical [LANE_N];
  word_t exp_q [$];
  blk_t  lane_q [LANE_N][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic blk_t randBlock();
    return blk_t'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic map_t randMap();
    int   perm [LANE_N];
    int   j, tmp;
    map_t v = '0;
    for (int i = 0; i < LANE_N; i++) perm[i] = i;
    for (int i = LANE_N - 1; i > 0; i--) begin
      j = int'($urandom_range(i));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int p = 0; p < LANE_N; p++) v[p*LANE_N + perm[p]] = 1'b1;
    return v;
  endfunction

  function automatic void clearModel();
    exp_q.delete();
    for (int p = 0; p < LANE_N; p++) lane_q[p].delete();
  endfunction

  // Block j of the aligned stream is the j-th post-AM data block of every lane.
  function automatic void modelWrite(input int p, input blk_t b);
    bit    all_ready = 1'b1;
    word_t w = '0;
    lane_q[p].push_back(b);
    for (int q = 0; q < LANE_N; q++) if (lane_q[q].size() == 0) all_ready = 1'b0;
    if (all_ready) begin
      for (int q = 0; q < LANE_N; q++) w[logical[q]*BLOCK_W +: BLOCK_W] = lane_q[q].pop_front();
      exp_q.push_back(w);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (!err_allowed) checkOutput("err_o", word_t'(rx.err_o), '0);
      if (rx.err_o) begin
        err_seen++;
        checkOutput("err_deskew", word_t'(rx.deskew_v_o), '0);
        checkOutput("err_valid", word_t'(rx.valid_o), '0);
      end
      if (rx.valid_o) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        checkOutput("valid_deskew", word_t'(rx.deskew_v_o), word_t'(1));
        if (exp_q.size() == 0) checkOutput("unexpected_valid", word_t'(rx.valid_o), '0);
        else checkOutput("block_o", rx.block_o, exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input map_t lane_vec, input int n_cycles, input int am2_k,
                               input int drop_at, input bit gaps, input bit use_model);
    int   t = 0;
    int   tmax = 0;
    bit   dropped = 1'b0;
    bit   am;
    blk_t b;
    for (int p = 0; p < LANE_N; p++) begin
      logical[p] = 0;
      for (int k = 0; k < LANE_N; k++) if (lane_vec[p*LANE_N + k]) logical[p] = k;
      if (offs[p] > tmax) tmax = offs[p];
    end
    clearModel();
    first_valid_cyc = -1;
    first_data_cyc  = -1;
    @(posedge clk); #1;
    rx.lane_i   = lane_vec;
    rx.lock_v_i = '1;
    rx.valid_i  = '0;
    rx.am_v_i   = '0;
    repeat (2) @(posedge clk);
    while (t < n_cycles && !dropped) begin
      @(posedge clk); #1;
      if (t == drop_at) begin
        rx.lock_v_i = 4'b1101;
        rx.valid_i  = '0;
        rx.am_v_i   = '0;
        @(posedge clk); #1;
        clearModel();
        @(negedge clk);
        checkOutput("drop_deskew", word_t'(rx.deskew_v_o), '0);
        checkOutput("drop_valid", word_t'(rx.valid_o), '0);
        dropped = 1'b1;
      end else if (gaps && $urandom_range(7) == 0) begin
        rx.valid_i = '0;
        rx.am_v_i  = '0;
      end else begin
        for (int p = 0; p < LANE_N; p++) begin
          b  = randBlock();
          am = (t == offs[p]) || (am2_k > 0 && t == offs[p] + am2_k);
          rx.valid_i[p] = 1'b1;
          rx.am_v_i[p]  = am;
          rx.block_i[p*BLOCK_W +: BLOCK_W] = b;
          if (use_model && t > offs[p] && !am) modelWrite(p, b);
        end
        if (t == tmax + 1) first_data_cyc = cyc;
        t++;
      end
    end
    @(posedge clk); #1;
    rx.valid_i = '0;
    rx.am_v_i  = '0;
    repeat (3 * MAX_SKEW) @(posedge clk);
    if (use_model && !dropped) begin
      checkOutput("drain", word_t'(exp_q.size()), '0);
      checkOutput("latency", word_t'(first_valid_cyc - first_data_cyc), word_t'(2));
    end
    @(negedge clk);
    checkOutput("locked_deskew", word_t'(rx.deskew_v_o), word_t'(use_model && !dropped));
    @(posedge clk); #1;
    rx.lock_v_i = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("unlock_deskew", word_t'(rx.deskew_v_o), '0);
    clearModel();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    map_t ident;
    ident       = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    reset       = 1'b1;
    rx.lock_v_i = '0;
    rx.lane_i   = '0;
    rx.valid_i  = '0;
    rx.am_v_i   = '0;
    rx.block_i  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", word_t'(rx.valid_o), '0);
    checkOutput("reset_block", rx.block_o, '0);
    checkOutput("reset_deskew", word_t'(rx.deskew_v_o), '0);
    checkOutput("reset_err", word_t'(rx.err_o), '0);
    reset = 1'b0;

    $display("[TB] identity map, zero skew");
    for (int p = 0; p < LANE_N; p++) offs[p] = 0;
    applyStimulus(ident, 40, 0, -1, 1'b0, 1'b1);

    $display("[TB] async reset during FILL");
    @(posedge clk); #1;
    rx.lane_i   = ident;
    rx.lock_v_i = '1;
    repeat (3) @(posedge clk);
    #1;
    rx.valid_i = 4'b0011;
    rx.am_v_i  = 4'b0011;
    @(posedge clk); #1;
    rx.am_v_i  = '0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checkOutput("midreset_valid", word_t'(rx.valid_o), '0);
    checkOutput("midreset_block", rx.block_o, '0);
    checkOutput("midreset_deskew", word_t'(rx.deskew_v_o), '0);
    checkOutput("midreset_err", word_t'(rx.err_o), '0);
    rx.valid_i  = '0;
    rx.lock_v_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] lane2 AM five cycles late");
    offs[0] = 0; offs[1] = 0; offs[2] = 5; offs[3] = 0;
    applyStimulus(ident, 60, 0, -1, 1'b0, 1'b1);

    $display("[TB] lane1 AM beyond skew limit");
    offs[0] = 0; offs[1] = MAX_SKEW + 1; offs[2] = 0; offs[3] = 0;
    err_seen    = 0;
    err_allowed = 1'b1;
    applyStimulus(ident, MAX_SKEW + 3, 0, -1, 1'b0, 1'b0);
    checkOutput("err_pulses", word_t'(err_seen), word_t'(1));
    err_allowed = 1'b0;

    $display("[TB] swapped physical 0 and 3");
    for (int p = 0; p < LANE_N; p++) offs[p] = int'($urandom_range(7));
    applyStimulus({4'b0001, 4'b0100, 4'b0010, 4'b1000}, 60, 25, -1, 1'b1, 1'b1);

    $display("[TB] invalid map stays idle");
    for (int p = 0; p < LANE_N; p++) offs[p] = 0;
    applyStimulus({4'b1000, 4'b0010, 4'b0010, 4'b0001}, 30, 0, -1, 1'b0, 1'b0);

    $display("[TB] second AM on all lanes");
    applyStimulus(randMap(), 120, 50, -1, 1'b0, 1'b1);

    $display("[TB] lock loss while aligned");
    for (int p = 0; p < LANE_N; p++) offs[p] = int'($urandom_range(8));
    applyStimulus(randMap(), 80, 0, 50, 1'b1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      $display("[TB] random skew run %0d", r);
      for (int p = 0; p < LANE_N; p++) offs[p] = int'($urandom_range(MAX_SKEW - 1));
      applyStimulus(randMap(), 100, int'($urandom_range(60, 30)), -1, 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
